// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer that shares one external ALU between two requesters.
module alu_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_gin,
    input  logic [31:0] alu_sum,
    input  logic        alu_zout,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_sum,
    output logic        resp_zout,
    output logic        resp_err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [3:0]  gin_q, gin_d;
    logic        owner_q, owner_d, last_q, last_d, ill_q, ill_d;
    logic        id_q, id_d, zout_q, zout_d, err_q, err_d, valid_q, valid_d, busy_q, busy_d;
    logic        gnt1, idle;

    always_comb begin
        idle       = state_q == IDLE;
        // on a tie, the requester not granted last time wins
        gnt1       = req1_valid && (!req0_valid || !last_q);
        req0_ready = idle && req0_valid && !gnt1;
        req1_ready = idle && gnt1;
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        gin_d      = gin_q;
        owner_d    = owner_q;
        last_d     = last_q;
        ill_d      = ill_q;
        id_d       = id_q;
        sum_d      = sum_q;
        zout_d     = zout_q;
        err_d      = err_q;
        case (state_q)
            IDLE: if (req0_valid || req1_valid) begin
                a_d     = gnt1 ? req1_a : req0_a;
                b_d     = gnt1 ? req1_b : req0_b;
                gin_d   = gnt1 ? req1_op : req0_op;
                ill_d   = (gnt1 ? req1_op : req0_op) > 4'b1011;
                owner_d = gnt1;
                last_d  = gnt1;
                cnt_d   = CNT_INIT;
                state_d = EXEC;
            end
            EXEC: if (cnt_q == 4'd0) begin
                id_d    = owner_q;
                sum_d   = ill_q ? 32'd0 : alu_sum;
                zout_d  = ill_q || alu_zout;
                err_d   = ill_q;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP: state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        valid_d = state_d == RESP;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            gin_q   <= 4'd0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            ill_q   <= 1'b0;
            id_q    <= 1'b0;
            sum_q   <= 32'd0;
            zout_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gin_q   <= gin_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            ill_q   <= ill_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            zout_q  <= zout_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_gin    = gin_q;
    assign resp_valid = valid_q;
    assign resp_id    = id_q;
    assign resp_sum   = sum_q;
    assign resp_zout  = zout_q;
    assign resp_err   = err_q;
    assign busy       = busy_q;
endmodule
